eco32_core_ifu_evm_mch: RTL and testbench

ECO32_CORE_IFU_EVM_MCH -- requirements
Module: eco32_core_ifu_evm_mch

---
 rtl/eco32_core_ifu_evm_mch.sv | 158 +++++++++++++++
 tb/tb_eco32_core_ifu_evm_mch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/eco32_core_ifu_evm_mch.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : eco32_core_ifu_evm_mch
// Description : Event-source multiplexer for the ECO32 IFU event machine.
//               Each source channel owns a one-deep slot (pending flag plus
//               captured event id / register index). A round-robin arbiter
//               picks one pending slot at a time, presents it to the thread
//               sequencer through a req/ack handshake and, with REARM=0,
//               waits for a full low->high cycle of sys_event_ena before it
//               grants again.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   i_stb           per-channel strobe, held by the source until i_ack
//   i_eid, i_erx    packed per-channel event id / register index
//   i_ack           per-channel capture acknowledge (combinational)
//   o_req, o_ack    request to / acceptance from the thread sequencer
//   o_ch/o_eid/o_erx granted channel, event id and register index
//   o_pend          slot-occupied flags
//   o_busy          arbiter FSM not idle
//   sys_event_ena   global event enable (gates new captures only)
//----------------------------------------------------------------------------
module eco32_core_ifu_evm_mch #(
  parameter int CHANNELS = 4,
  parameter int EID_W    = 4,
  parameter int ERX_W    = 4,
  parameter int REARM    = 0,
  localparam int CH_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       i_stb,
  input  logic [CHANNELS*EID_W-1:0] i_eid,
  input  logic [CHANNELS*ERX_W-1:0] i_erx,
  output logic [CHANNELS-1:0]       i_ack,
  output logic                      o_req,
  output logic [CH_W-1:0]           o_ch,
  output logic [EID_W-1:0]          o_eid,
  output logic [ERX_W-1:0]          o_erx,
  input  logic                      o_ack,
  output logic [CHANNELS-1:0]       o_pend,
  output logic                      o_busy,
  input  logic                      sys_event_ena
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WDIS = 3'd3;
  localparam logic [2:0] S_WENA = 3'd4;
  localparam logic [2:0] S_REL  = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [CHANNELS-1:0] r_pend;
  logic [EID_W-1:0]    r_seid [CHANNELS];
  logic [ERX_W-1:0]    r_serx [CHANNELS];
  logic                r_ena_q;
  logic [CH_W-1:0]     r_last;
  logic [CH_W-1:0]     r_g;
  logic [CH_W-1:0]     r_ch;
  logic [EID_W-1:0]    r_eid;
  logic [ERX_W-1:0]    r_erx;

  logic [CHANNELS-1:0] w_ack;
  logic [CHANNELS-1:0] w_clr;
  logic [CH_W-1:0]     w_next_g;
  int                  w_dist;
  int                  w_best;

  // A slot accepts only while empty; a set pend bit also keeps the source
  // holding its strobe. The rst term keeps every ack low during reset even
  // though the cleared pend bits would otherwise let a strobe through.
  assign w_ack  = i_stb & ~r_pend & {CHANNELS{sys_event_ena & ~rst}};
  assign i_ack  = w_ack;
  assign o_pend = r_pend;
  assign o_req  = (r_state == S_REQ);
  assign o_busy = (r_state != S_IDLE);
  assign o_ch   = r_ch;
  assign o_eid  = r_eid;
  assign o_erx  = r_erx;

  // The granted slot is released at the end of its LOAD cycle.
  assign w_clr = (r_state == S_LOAD) ?
                 ({{(CHANNELS-1){1'b0}}, 1'b1} << r_g) : '0;

  // Round-robin pick: the pending channel with the smallest upward distance
  // from last_grant+1 (modulo CHANNELS) wins.
  always_comb begin
    w_next_g = '0;
    w_best   = CHANNELS;
    w_dist   = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_dist = k - int'(r_last) - 1;
      if (w_dist < 0) w_dist = w_dist + CHANNELS;
      if (r_pend[k] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_next_g = CH_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (|r_pend) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_REQ;
      S_REQ:  if (o_ack) w_state_nxt = (REARM != 0) ? S_IDLE : S_WDIS;
      // The wait states look at the registered enable so the toggle is
      // observed on a clean, synchronised copy.
      S_WDIS: if (!r_ena_q) w_state_nxt = S_WENA;
      S_WENA: if (r_ena_q) w_state_nxt = S_REL;
      S_REL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_ena_q <= 1'b0;
      r_last  <= CH_W'(CHANNELS - 1);
      r_g     <= '0;
      r_ch    <= '0;
      r_eid   <= '0;
      r_erx   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_seid[k] <= '0;
        r_serx[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_ena_q <= sys_event_ena;
      // No set/clear conflict: the channel being cleared has its pend bit
      // set in LOAD, so its ack is low in that cycle.
      r_pend  <= (r_pend & ~w_clr) | w_ack;
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_ack[k]) begin
          r_seid[k] <= i_eid[k*EID_W +: EID_W];
          r_serx[k] <= i_erx[k*ERX_W +: ERX_W];
        end
      end
      if ((r_state == S_IDLE) && (|r_pend)) begin
        r_g <= w_next_g;
      end
      if (r_state == S_LOAD) begin
        r_ch   <= r_g;
        r_eid  <= r_seid[r_g];
        r_erx  <= r_serx[r_g];
        r_last <= r_g;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eco32_core_ifu_evm_mch.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_eco32_core_ifu_evm_mch
// Description : Directed self-checking bench for eco32_core_ifu_evm_mch.
//               Two instances share all source-side inputs: u_dut1 (REARM=1)
//               and u_dut0 (REARM=0); each has its own sequencer ack.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_eco32_core_ifu_evm_mch;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  stb;
  logic [15:0] eid;
  logic [15:0] erx;
  logic        ack0, ack1;

  logic [3:0]  iack0, iack1;
  logic        req0, req1;
  logic [1:0]  ch0, ch1;
  logic [3:0]  oeid0, oeid1;
  logic [3:0]  oerx0, oerx1;
  logic [3:0]  pend0, pend1;
  logic        busy0, busy1;

  int n_tests;
  int n_fail;

  eco32_core_ifu_evm_mch #(.CHANNELS(4), .EID_W(4), .ERX_W(4), .REARM(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_stb(stb), .i_eid(eid), .i_erx(erx), .i_ack(iack1),
    .o_req(req1), .o_ch(ch1), .o_eid(oeid1), .o_erx(oerx1), .o_ack(ack1),
    .o_pend(pend1), .o_busy(busy1), .sys_event_ena(ena)
  );

  eco32_core_ifu_evm_mch #(.CHANNELS(4), .EID_W(4), .ERX_W(4), .REARM(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_stb(stb), .i_eid(eid), .i_erx(erx), .i_ack(iack0),
    .o_req(req0), .o_ch(ch0), .o_eid(oeid0), .o_erx(oerx0), .o_ack(ack0),
    .o_pend(pend0), .o_busy(busy0), .sys_event_ena(ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [3:0] e, input logic [3:0] x);
    eid[ch*4 +: 4] = e;
    erx[ch*4 +: 4] = x;
  endtask

  task automatic do_reset();
    rst = 1'b1; stb = '0; ack0 = 1'b0; ack1 = 1'b0; ena = 1'b0; eid = '0; erx = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Bounded wait for o_req on the selected instance; never compares.
  task automatic wait_req(input bit sel, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? req1 : req0) === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; stb = 4'hF; eid = '1; erx = '1;
    step(); step();
    n_tests++; if ({req1, busy1} !== 2'b00) begin n_fail++; $display("FAIL reset_req_busy: got %b, want 00", {req1, busy1}); end
    n_tests++; if (pend1 !== 4'b0000) begin n_fail++; $display("FAIL reset_pend: got %b, want 0000", pend1); end
    n_tests++; if ({ch1, oeid1, oerx1} !== 10'd0) begin n_fail++; $display("FAIL reset_outputs: got ch=%0d eid=%0d erx=%0d, want 0 0 0", ch1, oeid1, oerx1); end
    n_tests++; if ({iack1, iack0} !== 8'h00) begin n_fail++; $display("FAIL reset_iack: got %b/%b, want 0000/0000", iack1, iack0); end
    stb = '0; ena = 1'b0; eid = '0; erx = '0; rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    ena = 1'b1; stb = 4'b0100; set_ch(2, 4'd5, 4'd9);
    #1;
    n_tests++; if (iack1 !== 4'b0100) begin n_fail++; $display("FAIL single_iack: got %b, want 0100", iack1); end
    step();
    stb = '0;
    n_tests++; if ({pend1, req1, busy1} !== 6'b0100_0_0) begin n_fail++; $display("FAIL single_capture: got pend=%b req=%b busy=%b, want 0100 0 0", pend1, req1, busy1); end
    step();
    n_tests++; if ({req1, busy1} !== 2'b01) begin n_fail++; $display("FAIL single_load: got req=%b busy=%b, want 0 1", req1, busy1); end
    step();
    n_tests++; if ({req1, ch1, oeid1, oerx1, pend1} !== {1'b1, 2'd2, 4'd5, 4'd9, 4'b0000}) begin
      n_fail++; $display("FAIL single_req: got req=%b ch=%0d eid=%0d erx=%0d pend=%b, want 1 2 5 9 0000", req1, ch1, oeid1, oerx1, pend1); end
    ack1 = 1'b1; step(); ack1 = 1'b0;
    n_tests++; if ({req1, busy1} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got req=%b busy=%b, want 0 0", req1, busy1); end
  endtask

  task automatic test_round_robin();
    bit got;
    do_reset();
    ena = 1'b1; stb = 4'b1011;
    set_ch(0, 4'd1, 4'd8); set_ch(1, 4'd2, 4'd9); set_ch(3, 4'd4, 4'd10);
    #1;
    n_tests++; if (iack1 !== 4'b1011) begin n_fail++; $display("FAIL rr_iack: got %b, want 1011", iack1); end
    step(); stb = '0;
    wait_req(1'b1, 8, got);
    n_tests++; if (!got || ch1 !== 2'd0 || oeid1 !== 4'd1) begin n_fail++; $display("FAIL rr_grant0: got req=%b ch=%0d eid=%0d, want 1 0 1", got, ch1, oeid1); end
    ack1 = 1'b1; step(); ack1 = 1'b0;
    wait_req(1'b1, 8, got);
    n_tests++; if (!got || ch1 !== 2'd1 || oeid1 !== 4'd2) begin n_fail++; $display("FAIL rr_grant1: got req=%b ch=%0d eid=%0d, want 1 1 2", got, ch1, oeid1); end
    // New channel-0 event while channel 1 is being granted.
    stb = 4'b0001; set_ch(0, 4'd7, 4'd3);
    #1;
    n_tests++; if (iack1 !== 4'b0001) begin n_fail++; $display("FAIL rr_iack_new0: got %b, want 0001", iack1); end
    step(); stb = '0;
    n_tests++; if (pend1 !== 4'b1001) begin n_fail++; $display("FAIL rr_pend_new0: got %b, want 1001", pend1); end
    ack1 = 1'b1; step(); ack1 = 1'b0;
    wait_req(1'b1, 8, got);
    n_tests++; if (!got || ch1 !== 2'd3 || oeid1 !== 4'd4 || oerx1 !== 4'd10) begin
      n_fail++; $display("FAIL rr_grant3: got req=%b ch=%0d eid=%0d erx=%0d, want 1 3 4 10", got, ch1, oeid1, oerx1); end
    ack1 = 1'b1; step(); ack1 = 1'b0;
    wait_req(1'b1, 8, got);
    n_tests++; if (!got || ch1 !== 2'd0 || oeid1 !== 4'd7 || oerx1 !== 4'd3) begin
      n_fail++; $display("FAIL rr_grant0_again: got req=%b ch=%0d eid=%0d erx=%0d, want 1 0 7 3", got, ch1, oeid1, oerx1); end
    ack1 = 1'b1; step(); ack1 = 1'b0;
    n_tests++; if ({pend1, busy1} !== 5'b0000_0) begin n_fail++; $display("FAIL rr_drained: got pend=%b busy=%b, want 0000 0", pend1, busy1); end
  endtask

  task automatic test_rearm();
    bit got;
    bit seen;
    do_reset();
    ena = 1'b1; stb = 4'b0011; set_ch(0, 4'd3, 4'd1); set_ch(1, 4'd6, 4'd2);
    step(); stb = '0;
    wait_req(1'b0, 8, got);
    n_tests++; if (!got || ch0 !== 2'd0 || oeid0 !== 4'd3) begin n_fail++; $display("FAIL rearm_first: got req=%b ch=%0d eid=%0d, want 1 0 3", got, ch0, oeid0); end
    ack0 = 1'b1; step(); ack0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req0 === 1'b1) seen = 1'b1;
      step();
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rearm_blocked: got req seen=%b, want 0", seen); end
    n_tests++; if ({busy0, pend0} !== 5'b1_0010) begin n_fail++; $display("FAIL rearm_waiting: got busy=%b pend=%b, want 1 0010", busy0, pend0); end
    ena = 1'b0; step(); step();
    ena = 1'b1;
    // Granted 4 cycles after the registered enable rises, i.e. 5 edges here.
    wait_req(1'b0, 6, got);
    n_tests++; if (!got || ch0 !== 2'd1 || oeid0 !== 4'd6 || oerx0 !== 4'd2) begin
      n_fail++; $display("FAIL rearm_second: got req=%b ch=%0d eid=%0d erx=%0d, want 1 1 6 2", got, ch0, oeid0, oerx0); end
    ack0 = 1'b1; step(); ack0 = 1'b0;
  endtask

  task automatic test_enable_gating();
    do_reset();
    stb = 4'b0001; set_ch(0, 4'd9, 4'd4);
    #1;
    n_tests++; if (iack1 !== 4'b0000) begin n_fail++; $display("FAIL gate_iack_off: got %b, want 0000", iack1); end
    step(); step();
    n_tests++; if (pend1 !== 4'b0000) begin n_fail++; $display("FAIL gate_pend_off: got %b, want 0000", pend1); end
    ena = 1'b1;
    #1;
    n_tests++; if (iack1 !== 4'b0001) begin n_fail++; $display("FAIL gate_iack_on: got %b, want 0001", iack1); end
    step(); stb = '0;
    n_tests++; if (pend1 !== 4'b0001) begin n_fail++; $display("FAIL gate_pend_on: got %b, want 0001", pend1); end
  endtask

  task automatic test_reset_mid_req();
    bit got;
    do_reset();
    ena = 1'b1; stb = 4'b1011;
    step(); stb = '0;
    wait_req(1'b1, 8, got);
    n_tests++; if (!got || pend1 !== 4'b1010 || ch1 !== 2'd0) begin n_fail++; $display("FAIL midrst_setup: got req=%b pend=%b ch=%0d, want 1 1010 0", got, pend1, ch1); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({req1, busy1, pend1} !== 6'b0_0_0000) begin n_fail++; $display("FAIL midrst_async: got req=%b busy=%b pend=%b, want 0 0 0000", req1, busy1, pend1); end
    @(negedge clk);
    rst = 1'b0; stb = 4'b1001; set_ch(0, 4'd2, 4'd6); set_ch(3, 4'd5, 4'd7);
    step(); stb = '0;
    wait_req(1'b1, 8, got);
    n_tests++; if (!got || ch1 !== 2'd0 || oeid1 !== 4'd2) begin n_fail++; $display("FAIL midrst_priority: got req=%b ch=%0d eid=%0d, want 1 0 2", got, ch1, oeid1); end
    ack1 = 1'b1; step(); ack1 = 1'b0;
  endtask

  task automatic test_held_strobe();
    do_reset();
    ena = 1'b1; stb = 4'b0010; set_ch(1, 4'd3, 4'd1);
    step();
    n_tests++; if (pend1 !== 4'b0010) begin n_fail++; $display("FAIL held_capture: got pend=%b, want 0010", pend1); end
    step();
    // LOAD cycle: slot still occupied, so the held strobe is not acked.
    n_tests++; if ({busy1, req1, iack1[1]} !== 3'b100) begin n_fail++; $display("FAIL held_load: got busy=%b req=%b iack1=%b, want 1 0 0", busy1, req1, iack1[1]); end
    set_ch(1, 4'd6, 4'd2);
    step();
    n_tests++; if ({req1, iack1[1], oeid1} !== {1'b1, 1'b1, 4'd3}) begin n_fail++; $display("FAIL held_req: got req=%b iack1=%b eid=%0d, want 1 1 3", req1, iack1[1], oeid1); end
    ack1 = 1'b1; step(); ack1 = 1'b0; stb = '0;
    n_tests++; if ({oeid1, pend1} !== {4'd3, 4'b0010}) begin n_fail++; $display("FAIL held_recapture: got eid=%0d pend=%b, want 3 0010", oeid1, pend1); end
    step();
    n_tests++; if ({busy1, req1, oeid1} !== {1'b1, 1'b0, 4'd3}) begin n_fail++; $display("FAIL held_second_load: got busy=%b req=%b eid=%0d, want 1 0 3", busy1, req1, oeid1); end
    step();
    n_tests++; if ({req1, oeid1, oerx1} !== {1'b1, 4'd6, 4'd2}) begin n_fail++; $display("FAIL held_second_req: got req=%b eid=%0d erx=%0d, want 1 6 2", req1, oeid1, oerx1); end
    ack1 = 1'b1; step(); ack1 = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; ena = 1'b0; stb = '0; eid = '0; erx = '0; ack0 = 1'b0; ack1 = 1'b0;
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_rearm();
    test_enable_gating();
    test_reset_mid_req();
    test_held_strobe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
